// File: rtl/vec_alu_pkg.sv
// ============================================================================
// Module      : vec_alu_pkg
// Description : Shared element-width types and helpers for the vector ALU.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vec_alu_pkg;

    typedef enum logic [1:0] {
        SEW8  = 2'b00,
        SEW16 = 2'b01,
        SEW32 = 2'b10
    } sew_e;

    localparam int ELEM_W_MIN = 8;

    // Elements of the selected width that fit in max_el minimum-width slots.
    function automatic int unsigned elem_count(input int unsigned max_el, input sew_e sew);
        return max_el >> sew;
    endfunction

    // The reserved encoding behaves as 32-bit elements.
    function automatic sew_e sew_decode(input logic [1:0] raw);
        return (raw == 2'b11) ? SEW32 : sew_e'(raw);
    endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_lane.sv
// ============================================================================
// Module      : addsub_lane
// Description : Combinational segmented add/sub for one lane; optional
//               saturation enabled by VADDSUB_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module addsub_lane
    import vec_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    input  logic [DATA_WIDTH/8-1:0] ci,
    input  logic [DATA_WIDTH/8-1:0] mask,
    input  logic                    sub,
    input  sew_e                    sew,
`ifdef VADDSUB_SAT_EN
    input  logic                    sat,
    input  logic                    signed_mode,
    output logic                    vxsat,
`endif
    output logic [DATA_WIDTH-1:0]   sum,
    output logic [DATA_WIDTH/8-1:0] co
);

    localparam int NB = DATA_WIDTH / ELEM_W_MIN;
`ifdef VADDSUB_SAT_EN
    localparam int IW = 4;
`else
    localparam int IW = 1;
`endif

    logic [NB-1:0]         w_ci_b;
    logic [NB-1:0]         w_mask_b;
    logic [NB-1:0]         w_start_b;
    logic [NB-1:0]         w_cout_b;
    logic [DATA_WIDTH-1:0] w_raw;
    logic [IW-1:0]         w_binfo [NB];
    logic [IW-1:0]         w_einfo [NB];
    logic [NB-1:0]         w_evalid;
`ifdef VADDSUB_SAT_EN
    logic [NB-1:0]         w_last_b;
    logic [NB-1:0]         w_ovf_b;
    logic [NB-1:0]         w_hi_b;
    logic [NB-1:0]         w_ovf_e;
    logic [NB-1:0]         w_hi_e;
`endif

    // Per-byte view of element-level controls.
    for (genvar i = 0; i < NB; i++) begin : g_byte
        assign w_ci_b[i]    = (sew == SEW8) ? ci[i]   : (sew == SEW16) ? ci[i/2]   : ci[i/4];
        assign w_mask_b[i]  = (sew == SEW8) ? mask[i] : (sew == SEW16) ? mask[i/2] : mask[i/4];
        assign w_start_b[i] = (sew == SEW8) || ((sew == SEW16) && (i % 2 == 0)) || (i % 4 == 0);
`ifdef VADDSUB_SAT_EN
        assign w_last_b[i]  = (sew == SEW8) || ((sew == SEW16) && (i % 2 == 1))
                              || ((sew == SEW32) && (i % 4 == 3));
        assign w_ovf_b[i]   = (sew == SEW8) ? w_ovf_e[i] : (sew == SEW16) ? w_ovf_e[i/2] : w_ovf_e[i/4];
        assign w_hi_b[i]    = (sew == SEW8) ? w_hi_e[i]  : (sew == SEW16) ? w_hi_e[i/2]  : w_hi_e[i/4];

        logic [7:0] w_sat_byte;
        assign w_sat_byte = w_hi_b[i] ? ((signed_mode && w_last_b[i]) ? 8'h7F : 8'hFF)
                                      : ((signed_mode && w_last_b[i]) ? 8'h80 : 8'h00);
        assign sum[i*8 +: 8] = !w_mask_b[i]             ? a[i*8 +: 8] :
                               (sat && w_ovf_b[i])      ? w_sat_byte  : w_raw[i*8 +: 8];
`else
        assign sum[i*8 +: 8] = w_mask_b[i] ? w_raw[i*8 +: 8] : a[i*8 +: 8];
`endif
    end

    // Byte-serial ripple; the chain restarts at each element's first byte.
    always_comb begin
        logic       v_carry;
        logic       v_cin;
        logic [8:0] v_t;
        v_carry  = 1'b0;
        v_cin    = 1'b0;
        v_t      = '0;
        w_raw    = '0;
        w_cout_b = '0;
        for (int i = 0; i < NB; i++) begin
            v_cin = w_start_b[i] ? (w_ci_b[i] ^ sub) : v_carry;
            v_t   = {1'b0, a[i*8 +: 8]} + {1'b0, b[i*8 +: 8] ^ {8{sub}}} + {8'd0, v_cin};
            w_raw[i*8 +: 8] = v_t[7:0];
            w_cout_b[i]     = v_t[8];
            v_carry         = v_t[8];
            w_binfo[i]      = '0;
            w_binfo[i][0]   = v_t[8];
`ifdef VADDSUB_SAT_EN
            w_binfo[i][1]   = v_t[7];
            w_binfo[i][2]   = b[i*8+7] ^ sub;
            w_binfo[i][3]   = a[i*8+7];
`endif
        end
    end

    // Gather carry and sign info from each element's most significant byte.
    for (genvar e = 0; e < NB; e++) begin : g_elem
        if (e < NB / 4) begin : g_any_sew
            assign w_einfo[e]  = (sew == SEW8)  ? w_binfo[e] :
                                 (sew == SEW16) ? w_binfo[2*e+1] : w_binfo[4*e+3];
            assign w_evalid[e] = 1'b1;
        end else if (e < NB / 2) begin : g_sew8_16
            assign w_einfo[e]  = (sew == SEW8) ? w_binfo[e] : w_binfo[2*e+1];
            assign w_evalid[e] = (sew != SEW32);
        end else begin : g_sew8_only
            assign w_einfo[e]  = w_binfo[e];
            assign w_evalid[e] = (sew == SEW8);
        end

        assign co[e] = w_evalid[e] & mask[e] & (w_einfo[e][0] ^ sub);

`ifdef VADDSUB_SAT_EN
        assign w_ovf_e[e] = w_evalid[e] & (signed_mode
                            ? ((w_einfo[e][3] == w_einfo[e][2]) && (w_einfo[e][1] != w_einfo[e][3]))
                            : (w_einfo[e][0] ^ sub));
        assign w_hi_e[e]  = signed_mode ? ~w_einfo[e][3] : ~sub;
`endif
    end

`ifdef VADDSUB_SAT_EN
    assign vxsat = sat & (|(w_ovf_e & mask));
`endif

endmodule

`default_nettype wire

// File: rtl/vaddsub_pipe.sv
// ============================================================================
// Module      : vaddsub_pipe
// Description : Two-stage multi-lane segmented add/sub with valid/ready;
//               optional saturation enabled by VADDSUB_SAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vaddsub_pipe
    import vec_alu_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int LANES      = 4,
    localparam int NEL        = LANES * DATA_WIDTH / 8
) (
    input  logic                        module_clk_i,
    input  logic                        module_rst_ni,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [LANES*DATA_WIDTH-1:0] a_i,
    input  logic [LANES*DATA_WIDTH-1:0] b_i,
    input  logic [NEL-1:0]              ci_i,
    input  logic [NEL-1:0]              mask_i,
    input  logic                        sub_i,
    input  logic [1:0]                  sew_i,
`ifdef VADDSUB_SAT_EN
    input  logic                        sat_i,
    input  logic                        signed_i,
    output logic                        vxsat_o,
`endif
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [LANES*DATA_WIDTH-1:0] sum_o,
    output logic [NEL-1:0]              co_o
);

    localparam int TW = LANES * DATA_WIDTH;
    localparam int NB = DATA_WIDTH / ELEM_W_MIN;

    logic          w_stall;
    logic          r_s1_valid;
    logic [TW-1:0] r_s1_a;
    logic [TW-1:0] r_s1_b;
    logic [NEL-1:0] r_s1_ci;
    logic [NEL-1:0] r_s1_mask;
    logic          r_s1_sub;
    sew_e          r_s1_sew;
    logic          r_out_valid;
    logic [TW-1:0] r_sum;
    logic [NEL-1:0] r_co;

    logic [TW-1:0]  w_sum;
    logic [NEL-1:0] w_co;
    logic [NEL-1:0] w_co_pos [LANES];
    int unsigned    w_lane_el;
`ifdef VADDSUB_SAT_EN
    logic             r_s1_sat;
    logic             r_s1_signed;
    logic             r_vxsat;
    logic [LANES-1:0] w_vxsat_l;
`endif

    assign w_stall    = r_out_valid & ~out_ready_i;
    assign in_ready_o = ~w_stall;

    // Bubbles load zeroed operands so the adders see no toggling.
    always_ff @(posedge module_clk_i or negedge module_rst_ni) begin
        if (!module_rst_ni) begin
            r_s1_valid  <= 1'b0;
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_ci     <= '0;
            r_s1_mask   <= '0;
            r_s1_sub    <= 1'b0;
            r_s1_sew    <= SEW8;
`ifdef VADDSUB_SAT_EN
            r_s1_sat    <= 1'b0;
            r_s1_signed <= 1'b0;
`endif
        end else if (!w_stall) begin
            r_s1_valid  <= in_valid_i;
            r_s1_a      <= in_valid_i ? a_i    : '0;
            r_s1_b      <= in_valid_i ? b_i    : '0;
            r_s1_ci     <= in_valid_i ? ci_i   : '0;
            r_s1_mask   <= in_valid_i ? mask_i : '0;
            r_s1_sub    <= in_valid_i & sub_i;
            r_s1_sew    <= in_valid_i ? sew_decode(sew_i) : SEW8;
`ifdef VADDSUB_SAT_EN
            r_s1_sat    <= in_valid_i & sat_i;
            r_s1_signed <= in_valid_i & signed_i;
`endif
        end
    end

    assign w_lane_el = elem_count(NB, r_s1_sew);

    // Element k of the op lives in lane k / w_lane_el.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [NB-1:0] w_lane_ci;
        logic [NB-1:0] w_lane_mask;
        logic [NB-1:0] w_lane_co;

        assign w_lane_ci   = NB'(r_s1_ci   >> (l * w_lane_el));
        assign w_lane_mask = NB'(r_s1_mask >> (l * w_lane_el));

        addsub_lane #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_lane (
            .a           (r_s1_a[l*DATA_WIDTH +: DATA_WIDTH]),
            .b           (r_s1_b[l*DATA_WIDTH +: DATA_WIDTH]),
            .ci          (w_lane_ci),
            .mask        (w_lane_mask),
            .sub         (r_s1_sub),
            .sew         (r_s1_sew),
`ifdef VADDSUB_SAT_EN
            .sat         (r_s1_sat),
            .signed_mode (r_s1_signed),
            .vxsat       (w_vxsat_l[l]),
`endif
            .sum         (w_sum[l*DATA_WIDTH +: DATA_WIDTH]),
            .co          (w_lane_co)
        );

        assign w_co_pos[l] = NEL'(w_lane_co) << (l * w_lane_el);
    end

    always_comb begin
        w_co = '0;
        for (int l = 0; l < LANES; l++) begin
            w_co = w_co | w_co_pos[l];
        end
    end

    always_ff @(posedge module_clk_i or negedge module_rst_ni) begin
        if (!module_rst_ni) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_co        <= '0;
`ifdef VADDSUB_SAT_EN
            r_vxsat     <= 1'b0;
`endif
        end else if (!w_stall) begin
            r_out_valid <= r_s1_valid;
            r_sum       <= w_sum;
            r_co        <= w_co;
`ifdef VADDSUB_SAT_EN
            r_vxsat     <= |w_vxsat_l;
`endif
        end
    end

    assign out_valid_o = r_out_valid;
    assign sum_o       = r_sum;
    assign co_o        = r_co;
`ifdef VADDSUB_SAT_EN
    assign vxsat_o     = r_vxsat;
`endif

endmodule

`default_nettype wire
